// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared definitions for the BCD countdown timer: the control FSM state
// type and the active-low seven-segment patterns, ordered {a,b,c,d,e,f,g}.
// No ports.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/countdown_timer_mux_seg7_decode.sv
// seg7_decode
// Combinational BCD digit to active-low seven-segment pattern.
// Ports:
//   bcd  in  4  BCD digit (0..9)
//   seg  out 7  active-low segments {a,b,c,d,e,f,g}; codes above 9 show blank
module seg7_decode
    import countdown_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_timer_mux.sv
// countdown_timer_mux
// Parametrised BCD down counter with start/pause, optional auto-reload,
// a terminal-count pulse and a time-multiplexed common-anode display driver.
// Ports:
//   clk       in  1         system clock, rising edge
//   rst_n     in  1         asynchronous active-low reset
//   load      in  1         load load_val (clamped per digit to 9) into count and reload
//   load_val  in  4*DIGITS  BCD start value, digit 0 in [3:0]
//   start     in  1         start/resume counting
//   pause     in  1         suspend counting
//   wrap_en   in  1         reload and continue when the count reaches zero
//   seg       out 7         active-low segments {a..g} for the scanned digit
//   an        out DIGITS    active-low one-hot digit enable
//   running   out 1         high while counting
//   done      out 1         one-cycle pulse when the count first reads zero
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | loaded or reset, waiting for start
// ST_RUN     | prescaler running, count decrements on each tick
// ST_PAUSED  | counting suspended, prescaler value retained
// ST_DONE    | count reached zero without reload; only load leaves it
module countdown_timer_mux
    import countdown_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  wrap_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  running,
    output logic                  done
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    state_e                state, state_nxt;
    logic [4*DIGITS-1:0]   count, count_nxt;
    logic [4*DIGITS-1:0]   reload, reload_nxt;
    logic [TW-1:0]         tick_cnt, tick_nxt;
    logic                  done_nxt;

    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         dig_idx;

    logic [4*DIGITS-1:0]   load_clamped;
    logic [4*DIGITS-1:0]   count_dec;
    logic [DIGITS-1:0]     borrow;
    logic [DIGITS-1:0]     upper_zero;

    logic [3:0]            cur_digit;
    logic                  disp_blank;
    logic [6:0]            dec_seg;

    // borrow[g]: every digit below g is zero, so digit g must decrement.
    // upper_zero[g]: digit g and all digits above it are zero.
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] dig;
        assign dig = count[4*g +: 4];

        assign load_clamped[4*g +: 4] = (load_val[4*g +: 4] > 4'd9) ? 4'd9 : load_val[4*g +: 4];

        assign count_dec[4*g +: 4] = !borrow[g]    ? dig   :
                                     (dig == 4'd0) ? 4'd9  : dig - 4'd1;

        if (g < DIGITS - 1) begin : g_chain
            assign borrow[g+1]   = borrow[g] && (dig == 4'd0);
            assign upper_zero[g] = (dig == 4'd0) && upper_zero[g+1];
        end else begin : g_top
            assign upper_zero[g] = (dig == 4'd0);
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        tick_nxt   = tick_cnt;
        done_nxt   = 1'b0;

        if (load) begin
            count_nxt  = load_clamped;
            reload_nxt = load_clamped;
            tick_nxt   = '0;
            state_nxt  = ST_IDLE;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pause) begin
                        state_nxt = ST_PAUSED;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_nxt = '0;
                        // A zero count in RUN only survives from a wrap: show it
                        // for one full tick, then restart from the reload value.
                        if (count == '0) begin
                            count_nxt = reload;
                        end else begin
                            count_nxt = count_dec;
                            if (count_dec == '0) begin
                                done_nxt = 1'b1;
                                if (!wrap_en || (reload == '0))
                                    state_nxt = ST_DONE;
                            end
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                ST_IDLE, ST_PAUSED: begin
                    if (!pause && start && (count != '0))
                        state_nxt = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            reload   <= '0;
            tick_cnt <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            reload   <= reload_nxt;
            tick_cnt <= tick_nxt;
            running  <= (state_nxt == ST_RUN);
            done     <= done_nxt;
        end
    end

    always_comb begin
        cur_digit  = '0;
        disp_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx == IW'(i)) begin
                cur_digit  = count[4*i +: 4];
                disp_blank = (BLANK_LZ != 0) && (i != 0) && upper_zero[i];
            end
        end
    end

    seg7_decode u_seg7_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            an       <= ~(DIGITS'(1));
            seg      <= SEG_0;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= ~(DIGITS'(1) << dig_idx);
            seg <= disp_blank ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_countdown_timer_mux.sv
// tb_countdown_timer_mux
// Directed and random stimulus for countdown_timer_mux (DIGITS=2, TICK_DIV=4,
// SCAN_DIV=2), with and without leading-zero blanking, checked every cycle
// against a decimal-integer model of the timer and display.
module tb_countdown_timer_mux;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    localparam int MD_IDLE   = 0;
    localparam int MD_RUN    = 1;
    localparam int MD_PAUSED = 2;
    localparam int MD_DONE   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       wrap_en = 1'b0;

    logic [6:0] seg, seg_b;
    logic [1:0] an, an_b;
    logic       running, running_b, done, done_b;

    always #5 clk = ~clk;

    countdown_timer_mux #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .wrap_en(wrap_en), .seg(seg), .an(an), .running(running), .done(done)
    );

    countdown_timer_mux #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .wrap_en(wrap_en), .seg(seg_b), .an(an_b), .running(running_b), .done(done_b)
    );

    int n_total = 0;
    int n_bad   = 0;
    int done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_mode, m_cnt, m_rel, m_pre, m_k;
    logic [6:0] m_seg, m_seg_b;
    logic [1:0] m_an;
    logic       m_run, m_done;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pow10(input int i);
        int r = 1;
        for (int j = 0; j < i; j++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd_value(input logic [7:0] v);
        int hi, lo;
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic model_reset();
        m_mode = MD_IDLE; m_cnt = 0; m_rel = 0; m_pre = 0; m_k = 0;
        m_an = 2'b10; m_seg = 7'b0000001; m_seg_b = 7'b0000001;
        m_run = 1'b0; m_done = 1'b0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        int idx, d;
        idx = (m_k / SCAN_DIV) % DIGITS;
        m_an = 2'b11;
        m_an[idx] = 1'b0;
        d = (m_cnt / pow10(idx)) % 10;
        m_seg = seg_of(d);
        m_seg_b = (idx > 0 && (m_cnt / pow10(idx)) == 0) ? 7'b1111111 : seg_of(d);
        m_k++;

        m_done = 1'b0;
        if (load) begin
            m_cnt = bcd_value(load_val);
            m_rel = m_cnt;
            m_pre = 0;
            m_mode = MD_IDLE;
        end else if (m_mode == MD_RUN) begin
            if (pause) begin
                m_mode = MD_PAUSED;
            end else if (m_pre == TICK_DIV - 1) begin
                m_pre = 0;
                if (m_cnt == 0) begin
                    m_cnt = m_rel;
                end else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_done = 1'b1;
                        if (!wrap_en || m_rel == 0) m_mode = MD_DONE;
                    end
                end
            end else begin
                m_pre++;
            end
        end else if ((m_mode == MD_IDLE || m_mode == MD_PAUSED) && !pause && start && m_cnt != 0) begin
            m_mode = MD_RUN;
        end
        m_run = (m_mode == MD_RUN);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic compare_all();
        chk("an", an, m_an);
        chk("an_b", an_b, m_an);
        chk("seg", seg, m_seg);
        chk("seg_b", seg_b, m_seg_b);
        chk("running", running, m_run);
        chk("running_b", running_b, m_run);
        chk("done", done, m_done);
        chk("done_b", done_b, m_done);
        if (done === 1'b1) done_seen++;
    endtask

    task automatic run_cycle(input logic l, input logic [7:0] lv, input logic s,
                             input logic p, input logic w);
        @(negedge clk);
        load = l; load_val = lv; start = s; pause = p; wrap_en = w;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n, input logic w);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 8'h00, 1'b0, 1'b0, w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        load = 1'b0; start = 1'b0; pause = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_an", an, 2'b10);
        chk("rst_seg", seg, 7'b0000001);
        chk("rst_seg_b", seg_b, 7'b0000001);
        chk("rst_running", running, 1'b0);
        chk("rst_done", done, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // idle scan: an alternates every SCAN_DIV cycles, seg shows 0
        for (int k = 1; k <= 8; k++) begin
            run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            chk("idle_an", an, (((k - 1) / 2) % 2 == 1) ? 2'b01 : 2'b10);
            chk("idle_seg", seg, 7'b0000001);
        end

        // 12 down to 0 without wrap; one done pulse, later start ignored
        done_seen = 0;
        run_cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle_cycles(12 * TICK_DIV + 6, 1'b0);
        chk("nowrap_dones", done_seen, 1);
        run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle_cycles(6, 1'b0);
        chk("done_start_ignored", running, 1'b0);

        // auto-reload from 3: done at each zero, running stays high
        done_seen = 0;
        run_cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle_cycles(40, 1'b1);
        chk("wrap_dones", done_seen, 2);
        chk("wrap_running", running, 1'b1);

        // pause after two prescaler cycles, hold, resume
        run_cycle(1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        run_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle_cycles(10, 1'b0);
        run_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);   // pause beats start
        idle_cycles(2, 1'b0);
        run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle_cycles(12, 1'b0);

        // clamp, load while running, load+start together, reset mid-count
        run_cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);
        run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle_cycles(9, 1'b0);
        run_cycle(1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
        chk("load_start_idle", running, 1'b0);
        idle_cycles(4, 1'b0);
        run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle_cycles(7, 1'b0);
        do_reset();
        idle_cycles(4, 1'b0);

        // leading-zero blanking on 07
        run_cycle(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
        idle_cycles(8, 1'b0);

        // load coinciding with the tick that would reach zero
        run_cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle_cycles(3, 1'b0);
        run_cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);

        // random traffic
        begin
            logic w = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                logic       l, s, p;
                logic [7:0] v;
                if ($urandom_range(0, 599) == 0) begin
                    do_reset();
                end else begin
                    if ($urandom_range(0, 49) == 0) w = ~w;
                    l = ($urandom_range(0, 59) == 0);
                    s = ($urandom_range(0, 5) == 0);
                    p = ($urandom_range(0, 14) == 0);
                    v = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 1) == 0) v[7:4] = 4'($urandom_range(0, 2));
                    run_cycle(l, v, s, p, w);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer_mux.md
# countdown_timer_mux

Parametrised BCD countdown timer with a time-multiplexed, active-low seven-segment display driver. It is the next generation of the lab-board down counter: the digit count and tick rate are set by parameters, the start value is loadable, and it adds start/pause control, optional auto-reload and a terminal-count pulse. It sits between the board clock and button/switch inputs and the common-anode display, replacing the separate clock divider with internal prescalers.

## Interface
- DIGITS, 4, number of BCD digits counted and displayed (1–8)
- TICK_DIV, 50_000_000, clk cycles per count decrement (≥2)
- SCAN_DIV, 100_000, clk cycles each digit is driven before the scan advances (≥1)
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is never blanked)

- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  level-sampled; loads load_val into the count and the reload register
- load_val  in  4*DIGITS  BCD start value, digit 0 in bits [3:0]
- start  in  1  begin or resume counting
- pause  in  1  suspend counting
- wrap_en  in  1  1 = reload and continue at zero; 0 = stop at zero
- seg  out  7  active-low segments {a,b,c,d,e,f,g}
- an  out  DIGITS  active-low one-hot digit enables, bit i = digit i
- running  out  1  high while in RUN
- done  out  1  one-cycle pulse when the count reaches zero

## Operation
- States: IDLE, RUN, PAUSED, DONE. Per-cycle control priority: load > pause > start.
- load (any state): count and reload register ← load_val, with any digit >9 clamped to 9; prescaler cleared; next state IDLE.
- start: IDLE or PAUSED with count ≠ 0 → RUN. Ignored when count = 0 and in DONE.
- pause: RUN → PAUSED; the prescaler holds its value and is not cleared.
- RUN: the prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it generates a tick and returns to 0.
- On a tick, the count is decremented in BCD: digit 0 borrows into digit 1, a 0 digit becomes 9, and so on.
- When the decrement produces 0, done pulses in the same cycle the registered count first reads 0.
  - wrap_en = 0: next state DONE.
  - wrap_en = 1 and reload ≠ 0: stay in RUN; the next tick loads count ← reload, so 0 is displayed for one full tick.
  - wrap_en = 1 and reload = 0: DONE.
- DONE holds until load. running = (state == RUN).
- Display scan runs from reset in every state and is independent of the control FSM.
  - The scan prescaler counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the digit index advances i → i+1, wrapping DIGITS-1 → 0.
  - an = ~(1<<i). seg = decode(count digit i).
  - If BLANK_LZ = 1 and i > 0 and all digits ≥ i are zero, seg = 7'b1111111.
- Decode (active-low {a..g}): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.

## Timing
- Reset values: state IDLE, count 0, reload 0, both prescalers 0, digit index 0, an = ~1, seg = 7'b0000001, running 0, done 0.
- Reset assertion at any point, including mid-count, returns all of the above immediately.
- All outputs are registered.
- Latency: control inputs act on the next state one cycle after sampling.
- The first tick after start occurs TICK_DIV cycles after entry to RUN from IDLE. From PAUSED, it occurs at the remaining prescaler count.
- seg and an change together, one cycle after the scan prescaler wraps.
- load and start in the same cycle: load wins and the state stays IDLE. pause and start together: pause wins.
- A load that coincides with a tick: load wins and done does not pulse.

## Structure
- Shared package countdown_pkg holds:
  - the state enum (IDLE, RUN, PAUSED, DONE)
  - the segment pattern constants SEG_0..SEG_9 and SEG_BLANK
- One sub-module, seg7_decode: a combinational 4-bit BCD to active-low 7-segment decoder, instantiated once on the muxed digit.
- BCD decrement and borrow chain: a generate loop over DIGITS.

## Test plan
Bench uses DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
- Reset then idle → an alternates 2'b10/2'b01 every 2 cycles; seg = 0000001; running = 0.
- load 0x12, start, wrap_en = 0 → count 12→11→10→09…→00 every 4 cycles; done pulses once with count = 0x00; state DONE; later start ignored.
- load 0x03, wrap_en = 1, start → 03,02,01,00,03,02…; done pulses at each 00; running stays 1.
- Pause after 2 prescaler cycles, hold 10 cycles, start → next tick 2 cycles after resume; count unchanged during pause.
- load 0xA5 → count 0x95; load while RUN → IDLE with the new value; assert rst_n low mid-count → all reset values immediately.
- BLANK_LZ=1, load 0x07 → digit 1 seg = 1111111, digit 0 seg = 0001111.
